// File: rtl/hidden_layer_mac_sequencer.sv
// Sequences one hidden layer over a shared MAC: per neuron clear, N_INPUT accumulates (+bias), ack; then layer_done.
// Latency: start edge + N_NEURON*(N_INPUT+2[+1]) cycles + 1 DONE cycle with mac_ack tied high; all outputs registered-state Moore.
// Backpressure: mac_req holds with indices frozen until mac_ack; start ignored outside IDLE. Optional bias term: LAYER_BIAS_EN.
module hidden_layer_mac_sequencer #(
    parameter int N_INPUT  = 4,
    parameter int N_NEURON = 2,
    parameter int IW       = (N_INPUT  > 1) ? $clog2(N_INPUT)  : 1,
    parameter int NW       = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mac_ack_i,
    output logic          mac_clr_o,
    output logic          mac_req_o,
    output logic          bias_sel_o,
    output logic [IW-1:0] input_idx_o,
    output logic [NW-1:0] neuron_idx_o,
    output logic          ack_mac_o,
    output logic          busy_o,
    output logic          layer_done_o
);

    localparam logic [IW-1:0] LAST_IN  = IW'(N_INPUT - 1);
    localparam logic [NW-1:0] LAST_NEU = NW'(N_NEURON - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
`ifdef LAYER_BIAS_EN
        S_BIAS,
`endif
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] in_idx_q, in_idx_d;
    logic [NW-1:0] neu_idx_q, neu_idx_d;

    // State and index registers; reset abandons any pass in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            in_idx_q  <= '0;
            neu_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            neu_idx_q <= neu_idx_d;
        end
    end

    // Next-state / index update and Moore output decode from the current state.
    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        neu_idx_d    = neu_idx_q;
        mac_clr_o    = 1'b0;
        mac_req_o    = 1'b0;
        bias_sel_o   = 1'b0;
        ack_mac_o    = 1'b0;
        layer_done_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_CLEAR;
                    neu_idx_d = '0;
                end
            end
            S_CLEAR: begin
                mac_clr_o = 1'b1;
                in_idx_d  = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                mac_req_o = 1'b1;
                if (mac_ack_i) begin
                    if (in_idx_q == LAST_IN) begin
`ifdef LAYER_BIAS_EN
                        state_d = S_BIAS;
`else
                        state_d = S_NEXT;
`endif
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                    end
                end
            end
`ifdef LAYER_BIAS_EN
            // Bias request reuses the last input address; only bias_sel differs.
            S_BIAS: begin
                mac_req_o  = 1'b1;
                bias_sel_o = 1'b1;
                if (mac_ack_i) begin
                    state_d = S_NEXT;
                end
            end
`endif
            S_NEXT: begin
                ack_mac_o = 1'b1;
                if (neu_idx_q == LAST_NEU) begin
                    state_d = S_DONE;
                end else begin
                    neu_idx_d = neu_idx_q + NW'(1);
                    state_d   = S_CLEAR;
                end
            end
            S_DONE: begin
                layer_done_o = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q != S_IDLE);
    assign input_idx_o  = in_idx_q;
    assign neuron_idx_o = neu_idx_q;

endmodule
